serial_subtractor32: RTL and testbench
======================================

// Module: serial_subtractor32
// PURPOSE
//  Multi-cycle digit-serial unsigned subtractor with borrow in and out.
//  Computes {bout,diff} = in_1 - in_2 - bin, processing DIGIT bits per cycle, LSB digit first.
//  Valid/ready handshake on both the operand side and the result side.
//  Inverse-direction companion to the 32-bit ripple adder; used in the datapath where area matters more than latency.
// PARAMETERS
//  WIDTH  32  operand and result width; must be a multiple of DIGIT
//  DIGIT  4   bits processed per cycle; N = WIDTH/DIGIT slice cycles (8 by default)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  resetn     in   1      synchronous, active-low reset
//  in_valid   in   1      operands and bin are valid
//  in_ready   out  1      block accepts operands (IDLE only)
//  in_1       in   WIDTH  minuend
//  in_2       in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (in_1 - in_2 - bin) mod 2^WIDTH
//  bout       out  1      1 iff in_1 < in_2 + bin (unsigned)
// BEHAVIOUR
//  Reset (resetn=0 at rising edge)
//   - State goes to IDLE; slice counter = 0; internal borrow = 0.
//   - out_valid = 0, diff = 0, bout = 0; in_ready = 1 from the first cycle after reset.
//   - Reset mid-RUN or in DONE aborts the operation; the partial result is discarded and never presented.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: in_ready = 1.
//     - On in_valid & in_ready at edge t: capture in_1, in_2 and bin (borrow register = bin); counter = 0; go to RUN.
//   - RUN: in_ready = 0, out_valid = 0. Each cycle:
//     - Take DIGIT-bit slice k of each operand.
//     - slice = a_k - b_k - borrow, computed at DIGIT+1 bits.
//     - Low DIGIT bits go to slice k of the result register; borrow = MSB of the DIGIT+1-bit result.
//     - k increments.
//     - After slice N-1 (edge t+N): diff = full result, bout = final borrow; go to DONE.
//   - DONE: out_valid = 1; diff and bout are held stable while out_ready = 0.
//     - in_valid is ignored (in_ready = 0).
//     - On out_valid & out_ready: go to IDLE; out_valid = 0 next cycle; diff and bout keep their last values.
//  Latency: out_valid is high in cycle t+N+1 when the operands are accepted at edge t. Throughput: one operation per N+2 cycles minimum.
//  in_ready = (state == IDLE), combinational from state. No operand/result overlap.
//  Borrow ripples across slice boundaries through the borrow register only; no combinational path spans more than DIGIT bits.
//  Operands are registered at accept; changes on in_1, in_2 or bin during RUN or DONE have no effect.
//  Wrap-around: the counter resets to 0 on each accept; it does not free-run.
// TESTING
//  1. in_1=0x0000AD30, in_2=0x0000EFF5, bin=0 -> diff=0xFFFFBD3B, bout=1; out_valid exactly 9 cycles after the accept edge.
//  2. in_1=0x0000EDF9, in_2=0x0000DEF8, bin=1 -> diff=0x00000F00, bout=0.
//  3. in_1=0x0000EFAD, in_2=0x0000123D, bin=0 -> diff=0x0000DD70, bout=0.
//     Then in_1=0x80000000, in_2=0x00000001, bin=0 (borrow ripples across 7 slices) -> diff=0x7FFFFFFF, bout=0.
//  4. in_1=in_2=0x00000005, bin=1 -> diff=0xFFFFFFFF, bout=1.
//     Then in_1=0, in_2=0, bin=0 -> diff=0, bout=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with new operands.
//     -> diff/bout stable, in_ready=0, new operands ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
//  6. Reset in RUN: resetn=0 for 1 edge at slice 3.
//     -> out_valid=0, diff=0, bout=0, in_ready=1 next cycle.
//     A fresh operation afterwards returns a correct result (check with test 1 values).

Source files
------------

// File: rtl/serial_subtractor32.sv
// -----------------------------------------------------------------------------
// serial_subtractor32
//
// Digit-serial unsigned subtractor: {bout, diff} = in_1 - in_2 - bin.
// One DIGIT-bit slice is processed per clock, LSB slice first, so a full
// operation takes N = WIDTH/DIGIT cycles in RUN. The borrow is carried
// between slices in a register, which keeps the longest combinational path
// to a single DIGIT-bit subtract.
//
// Ports
//   clk        in   1      rising-edge clock
//   resetn     in   1      synchronous active-low reset
//   in_valid   in   1      in_1/in_2/bin are valid
//   in_ready   out  1      operands are accepted (high only in IDLE)
//   in_1       in   WIDTH  minuend
//   in_2       in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      diff/bout are valid (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   diff       out  WIDTH  (in_1 - in_2 - bin) mod 2^WIDTH
//   bout       out  1      1 when in_1 < in_2 + bin
//
// WIDTH must be a multiple of DIGIT, with at least two slices.
// -----------------------------------------------------------------------------
module serial_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operand registers are shifted right one slice per RUN cycle, so slice k
  // is always found in the low DIGIT bits; no slice-select mux is needed.
  logic [WIDTH-1:0] a_reg, b_reg;
  // Partial result fills from the top: after N shifts slice k sits at bit k*DIGIT.
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic [CW-1:0]    cnt_reg;
  logic [DIGIT:0]   slice_res;
  logic             last_slice;

  // One slice at DIGIT+1 bits; the extra MSB is the borrow out of the slice.
  assign slice_res = {1'b0, a_reg[DIGIT-1:0]}
                   - {1'b0, b_reg[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_reg};

  assign res_next   = {slice_res[DIGIT-1:0], res_reg[WIDTH-1:DIGIT]};
  assign last_slice = (cnt_reg == LAST_SLICE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= in_1;
            b_reg      <= in_2;
            borrow_reg <= bin;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> DIGIT;
          b_reg      <= b_reg >> DIGIT;
          res_reg    <= res_next;
          borrow_reg <= slice_res[DIGIT];
          cnt_reg    <= cnt_reg + CW'(1);
          // The visible result changes only when the last slice completes,
          // so an aborted operation never leaks a partial value.
          if (last_slice) begin
            diff_reg <= res_next;
            bout_reg <= slice_res[DIGIT];
          end
        end
        default: begin
          // DONE holds everything stable until the consumer takes the result.
        end
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor32.sv
module tb_serial_subtractor32;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk       = 1'b0;
  logic             resetn    = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_1      = '0;
  logic [WIDTH-1:0] in_2      = '0;
  logic             bin       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  serial_subtractor32 #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_1     (in_1),
    .in_2     (in_2),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
  );

  // Reference: plain wide arithmetic; the top bit is the borrow out.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic bi);
    return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic accept(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic bi);
    check({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_1     = a;
    in_2     = b;
    bin      = bi;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Scramble the inputs: the captured operands must be used.
    in_1     = $urandom;
    in_2     = $urandom;
    bin      = 1'($urandom_range(0, 1));
    check({tag, "/in_ready_run"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic bi,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b,
                        input int hold);
    int n;
    accept(tag, a, b, bi);
    wait_out(n);
    // Edges after the accept edge until out_valid (the 9th cycle counting the accept cycle).
    check({tag, "/latency"}, WIDTH'(n), WIDTH'(N));
    check({tag, "/diff"}, diff, exp_d);
    check({tag, "/bout"}, {31'd0, bout}, {31'd0, exp_b});
    repeat (hold) begin
      step();
      check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/hold_diff"}, diff, exp_d);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "/out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/in_ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, "/diff_kept"}, diff, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0]   exp_v;
    logic [WIDTH-1:0] ra, rb, pdiff;
    logic             rbi, pbout;
    int               n;

    // Reset
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    check("reset/in_ready", {31'd0, in_ready}, 32'd1);
    check("reset/out_valid", {31'd0, out_valid}, 32'd0);
    check("reset/diff", diff, 32'd0);
    check("reset/bout", {31'd0, bout}, 32'd0);

    // Directed vectors
    run_op("t1", 32'h0000AD30, 32'h0000EFF5, 1'b0, 32'hFFFFBD3B, 1'b1, 0);
    run_op("t2", 32'h0000EDF9, 32'h0000DEF8, 1'b1, 32'h00000F00, 1'b0, 1);
    run_op("t3a", 32'h0000EFAD, 32'h0000123D, 1'b0, 32'h0000DD70, 1'b0, 0);
    run_op("t3b", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 0);
    run_op("t4a", 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 0);
    run_op("t4b", 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 2);

    // Backpressure: result stays put and new operands are refused
    ra = 32'h12345678;
    rb = 32'h9ABCDEF0;
    exp_v = ref_sub(ra, rb, 1'b1);
    accept("bp", ra, rb, 1'b1);
    wait_out(n);
    check("bp/latency", WIDTH'(n), WIDTH'(N));
    pdiff = exp_v[WIDTH-1:0];
    pbout = exp_v[WIDTH];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_1     = $urandom;
      in_2     = $urandom;
      bin      = 1'($urandom_range(0, 1));
      step();
      check("bp/in_ready", {31'd0, in_ready}, 32'd0);
      check("bp/out_valid", {31'd0, out_valid}, 32'd1);
      check("bp/diff", diff, pdiff);
      check("bp/bout", {31'd0, bout}, {31'd0, pbout});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp/in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp/out_valid_after", {31'd0, out_valid}, 32'd0);
    repeat (12) step();
    check("bp/no_phantom_op", {31'd0, out_valid}, 32'd0);
    check("bp/still_idle", {31'd0, in_ready}, 32'd1);

    // Reset during RUN, at slice 3
    accept("rst", 32'h0000AD30, 32'h0000EFF5, 1'b0);
    repeat (3) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/diff", diff, 32'd0);
    check("rst/bout", {31'd0, bout}, 32'd0);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) step();
    check("rst/no_partial", {31'd0, out_valid}, 32'd0);
    run_op("rst_t1", 32'h0000AD30, 32'h0000EFF5, 1'b0, 32'hFFFFBD3B, 1'b1, 0);

    // Randomized operations against the reference
    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : ((i % 5 == 1) ? ra + 32'd1 : $urandom);
      rbi = 1'($urandom_range(0, 1));
      exp_v = ref_sub(ra, rb, rbi);
      run_op($sformatf("rnd%0d", i), ra, rb, rbi, exp_v[WIDTH-1:0], exp_v[WIDTH],
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
